// File: rtl/bch_soft_encoder_core_if.sv
// Request/response bundle of the BCH encoder core.
// The master side drives the config and message; the slave side returns status and codeword.
interface bch_soft_encoder_core_if #(
    parameter int N_MAX = 1023,
    parameter int T_MAX = 4,
    parameter int M_MAX = 10
);
    localparam int P_MAX = T_MAX * M_MAX;

    logic               start;
    logic [9:0]         n;
    logic [3:0]         t;
    logic [3:0]         m;
    logic [P_MAX:0]     gen_poly;
    logic [N_MAX-1:0]   msg_bits;
    logic               busy;
    logic               done;
    logic               cfg_err;
    logic [N_MAX-1:0]   codeword;

    modport master (
        output start, n, t, m, gen_poly, msg_bits,
        input  busy, done, cfg_err, codeword
    );

    modport slave (
        input  start, n, t, m, gen_poly, msg_bits,
        output busy, done, cfg_err, codeword
    );
endinterface

// File: rtl/bch_soft_encoder_core.sv
// Systematic binary BCH encoder: a serial LFSR divides x^p*m(x) by g(x), one message bit per cycle,
// and the codeword is assembled as {message, parity} in the layout the decoder consumes.
module bch_soft_encoder_core #(
    parameter int N_MAX = 1023,
    parameter int T_MAX = 4,
    parameter int M_MAX = 10
) (
    input  logic                    clk,
    input  logic                    rstn,
    bch_soft_encoder_core_if.slave  bus
);
    localparam int P_MAX = T_MAX * M_MAX;
    localparam int PW    = $clog2(P_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ENC, S_FIN} state_t;

    state_t             state_q, state_d;
    logic [9:0]         cnt_q, cnt_d;
    logic [P_MAX-1:0]   r_q, r_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;
    logic [N_MAX-1:0]   codeword_q, codeword_d;

    logic [9:0]         k_q, k_d;
    logic [PW-1:0]      p_q, p_d;
    logic [P_MAX-1:0]   gen_q, gen_d;
    logic [N_MAX-1:0]   msg_q, msg_d;

    logic [7:0]         p_full;
    logic [9:0]         k_new;
    logic               cfg_ok;
    logic               fb;
    logic [P_MAX-1:0]   p_mask;
    logic [P_MAX-1:0]   lfsr_next;
    logic [N_MAX-1:0]   cw_ok;

    // Configuration check on the live inputs; only consulted on the start edge.
    always_comb begin
        logic t_ok, m_ok, n_ok, p_ok, g_ok;
        p_full = 8'(bus.m) * 8'(bus.t);
        k_new  = bus.n - {2'b00, p_full};
        t_ok   = (bus.t != 4'd0) && (bus.t <= 4'(T_MAX));
        m_ok   = (bus.m >= 4'd2) && (bus.m <= 4'(M_MAX));
        n_ok   = ({1'b0, bus.n} <= 11'(N_MAX)) && ({1'b0, bus.n} < (11'd1 << bus.m));
        p_ok   = {2'b00, p_full} < bus.n;
        g_ok   = (p_full <= 8'(P_MAX)) ? bus.gen_poly[p_full[PW-1:0]] : 1'b0;
        cfg_ok = t_ok && m_ok && n_ok && p_ok && g_ok;
    end

    // Parity register shift; stages at or above p are held at zero by the mask.
    always_comb begin
        fb        = msg_q[cnt_q] ^ r_q[p_q - PW'(1)];
        p_mask    = ~({P_MAX{1'b1}} << p_q);
        lfsr_next = ({r_q[P_MAX-2:0], 1'b0} ^ ({P_MAX{fb}} & gen_q)) & p_mask;
        cw_ok     = {{(N_MAX-P_MAX){1'b0}}, r_q}
                  | ((msg_q & ~({N_MAX{1'b1}} << k_q)) << p_q);
    end

    always_comb begin
        // NOTE: every _d is given its hold value first, so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        err_d      = err_q;
        done_d     = 1'b0;
        cfg_err_d  = cfg_err_q;
        codeword_d = codeword_q;
        k_d        = k_q;
        p_d        = p_q;
        gen_d      = gen_q;
        msg_d      = msg_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    k_d   = k_new;
                    p_d   = p_full[PW-1:0];
                    gen_d = bus.gen_poly[P_MAX-1:0];
                    msg_d = bus.msg_bits;
                    if (cfg_ok) begin
                        state_d = S_ENC;
                        r_d     = '0;
                        cnt_d   = k_new - 10'd1;
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ENC: begin
                r_d = lfsr_next;
                if (cnt_q == 10'd0) state_d = S_FIN;
                else                cnt_d   = cnt_q - 10'd1;
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (err_q) begin
                    codeword_d = '0;
                    cfg_err_d  = 1'b1;
                end else begin
                    codeword_d = cw_ok;
                    cfg_err_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking (<=) in every clocked block so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            r_q        <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            codeword_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            err_q      <= err_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            codeword_q <= codeword_d;
        end
    end

    // NOTE: operand registers are left unreset; every accepted start reloads them before they are read.
    always_ff @(posedge clk) begin
        k_q   <= k_d;
        p_q   <= p_d;
        gen_q <= gen_d;
        msg_q <= msg_d;
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.cfg_err  = cfg_err_q;
    assign bus.codeword = codeword_q;
endmodule
